// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result collector for a single dsc_mul instance.
// It accepts a 4-operand tuple, runs the multiplier until ov or timeout, then holds the result until it is consumed.
module dsc_mul_seq #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 65544
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_c,
    input  logic [WIDTH-1:0]       in_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*WIDTH-1:0]     out_z,
    output logic [CNT_WIDTH-1:0]   out_cycles,
    output logic                   out_err,
    output logic                   mul_rst,
    output logic                   mul_en,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic [WIDTH-1:0]       mul_c,
    output logic [WIDTH-1:0]       mul_d,
    input  logic [4*WIDTH-1:0]     mul_z,
    input  logic                   mul_ov
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 any_zero;

    assign cnt_nxt  = cnt + CNT_WIDTH'(1);
    // A zero operand makes the product zero, so the multiplier is never started.
    assign any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);

    // NOTE: every state bit is updated with <= so all registers see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_cycles <= '0;
            out_err    <= 1'b0;
            mul_rst    <= 1'b1;
            mul_en     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_c      <= '0;
            mul_d      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mul_rst <= 1'b1;
                    mul_en  <= 1'b0;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        mul_c    <= in_c;
                        mul_d    <= in_d;
                        cnt      <= '0;
                        out_err  <= 1'b0;
                        if (any_zero) begin
                            out_z      <= '0;
                            out_cycles <= '0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= CLEAR;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    mul_rst <= 1'b0;
                    mul_en  <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    cnt <= cnt_nxt;
                    // A finish on the last allowed cycle still counts as success.
                    if (mul_ov || (cnt_nxt == TIMEOUT_C)) begin
                        out_z      <= mul_z;
                        out_cycles <= cnt_nxt;
                        out_err    <= !mul_ov;
                        mul_en     <= 1'b0;
                        mul_rst    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dsc_mul_seq.md
Name: dsc_mul_seq

Overview:
Operand sequencer and result collector that drives one dsc_mul instance.
- Accepts 4-operand tuples on a valid/ready input channel.
- Drives dsc_mul's rst/en/a..d, waits for its ov, then captures z and the elapsed cycle count.
- Presents the result on a valid/ready output channel.
- Sits between the binary datapath and the deterministic stochastic multiplier; it replaces bench-style wait/reset sequencing with synthesizable control.

Parameters:
WIDTH, 4, bits per operand (dsc_mul input width)
CNT_WIDTH, 32, width of the run-cycle counter and out_cycles
TIMEOUT, 65544, maximum RUN cycles before abort (2^(4*WIDTH)+8)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  operand tuple valid
in_ready  out  1  sequencer can accept a tuple
in_a, in_b, in_c, in_d  in  WIDTH each  unsigned operands
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_z  out  4*WIDTH  product captured from dsc_mul
out_cycles  out  CNT_WIDTH  RUN cycles consumed
out_err  out  1  timeout flag for this result
mul_rst  out  1  to dsc_mul rst (active-high)
mul_en  out  1  to dsc_mul en
mul_a, mul_b, mul_c, mul_d  out  WIDTH each  to dsc_mul a..d
mul_z  in  4*WIDTH  from dsc_mul z
mul_ov  in  1  from dsc_mul ov (operation finished)

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE.
  - Outputs: in_ready=0 during the reset cycle, 1 from the first cycle after release; out_valid=0; out_z=0; out_cycles=0; out_err=0; mul_rst=1; mul_en=0; mul_a..d=0; internal counter=0.
  - Reset mid-operation aborts immediately: no result is emitted and the dsc_mul is held in reset.
- States: IDLE, CLEAR, RUN, DONE. All outputs are registered.
- IDLE:
  - in_ready=1, mul_rst=1, mul_en=0.
  - On in_valid&in_ready: latch in_a..d into mul_a..d, clear counter, clear out_err.
  - If any operand == 0: go straight to DONE with out_z=0, out_cycles=0, out_err=0 (zero shortcut, no RUN).
  - Otherwise go to CLEAR.
- CLEAR:
  - Exactly one cycle; mul_rst=1, mul_en=0, in_ready=0.
  - Next state is RUN.
- RUN:
  - mul_rst=0, mul_en=1; counter increments by 1 every RUN cycle, including the cycle mul_ov is sampled high.
  - On mul_ov=1: next cycle out_z<=mul_z, out_cycles<=counter+1, out_err<=0, mul_en<=0, mul_rst<=1, state=DONE.
  - If counter+1 == TIMEOUT and mul_ov=0: same capture with out_err<=1, state=DONE.
- DONE:
  - out_valid=1; out_z, out_cycles and out_err are held stable until out_valid&out_ready.
  - After the handshake: next cycle out_valid=0, state=IDLE.
  - in_ready=0 throughout.
- Ignored inputs:
  - mul_ov is ignored outside RUN.
  - in_valid is ignored whenever in_ready=0; tuples are not queued.
- Operand stability: mul_a..d stay constant from acceptance until the next acceptance.
- Latency, nonzero tuple: accept edge T → CLEAR at T+1 → RUN from T+2 → out_valid at 1 cycle after mul_ov is sampled.
- Minimum accept-to-accept spacing for nonzero tuples: out_cycles + 4 cycles with out_ready tied high.
- Zero-tuple latency: out_valid 1 cycle after acceptance.
- Counter width: CNT_WIDTH must exceed log2(TIMEOUT); the counter never wraps because TIMEOUT bounds it.

Test Plan:
- a=b=c=d=15, out_ready=1, real dsc_mul attached → out_z=50625, out_err=0, 1≤out_cycles<TIMEOUT; out_valid rises 1 cycle after mul_ov.
- a=0, b=7, c=3, d=9 → out_valid 1 cycle after accept; out_z=0, out_cycles=0; mul_en never asserts.
- a=3, b=5, c=2, d=1 with out_ready=0 for 10 cycles after out_valid → out_z=30 and out_cycles held stable, in_ready=0, a new in_valid pulse is ignored; out_ready=1 → IDLE next cycle.
- Stub dsc_mul with mul_ov tied 0, TIMEOUT=20 → exactly 20 mul_en cycles, then out_err=1, out_cycles=20, mul_rst=1.
- rst=0 asserted 5 cycles into RUN → next cycle all outputs at reset values, no out_valid; a following tuple 2,2,2,2 → out_z=16.
- 10 back-to-back random tuples with in_valid held high → each out_z equals a*b*c*d; in_ready pulses exactly once per result.
